pattern_feeder: RTL and testbench



---
 rtl/pattern_feeder.sv | 148 ++++++++++++++
 tb/tb_pattern_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_feeder.sv
// pattern_feeder: FIFO-buffered pattern loader that spaces loads into the rotate register.
// Build option PATTERN_FEEDER_REPEAT_EN re-issues the last byte whenever the FIFO runs dry.
module pattern_feeder #(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [HOLD_W-1:0]      hold_cnt,
   output logic [7:0]             load_val,
   output logic                   load_en,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD
   } state_t;

   state_t            state;
   state_t            nxt;
   logic [7:0]        mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW-1:0]     rptr_n;
   logic [HOLD_W-1:0] hcnt;
   logic              rep_q;
   logic              nxt_rep;
   logic [7:0]        nxt_val;
   logic              push;
   logic              pop;
   logic [LW-1:0]     rem;

`ifdef PATTERN_FEEDER_REPEAT_EN
   logic [7:0]        last_val;
`endif

   assign in_ready = (level != LW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state == S_LOAD) && !rep_q;
   assign rptr_n   = rptr + AW'(pop);
   assign rem      = level - LW'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         rptr  <= rptr_n;
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wptr] <= in_data;
   end

   // Next-load decisions use the registered level, so a same-cycle push
   // is never needed as a bypass source.
   always_comb begin
      nxt     = state;
      nxt_rep = 1'b0;
      nxt_val = load_val;
      unique case (state)
         S_IDLE: begin
            if (level != '0) begin
               nxt     = S_LOAD;
               nxt_val = mem[rptr];
            end
         end
         S_LOAD: begin
            if (hold_cnt != '0) begin
               nxt = S_HOLD;
            end else if (rem != '0) begin
               nxt     = S_LOAD;
               nxt_val = mem[rptr_n];
            end else begin
`ifdef PATTERN_FEEDER_REPEAT_EN
               nxt     = S_LOAD;
               nxt_rep = 1'b1;
`else
               nxt     = S_IDLE;
`endif
            end
         end
         S_HOLD: begin
            if (hcnt == HOLD_W'(1)) begin
               if (level != '0) begin
                  nxt     = S_LOAD;
                  nxt_val = mem[rptr];
               end else begin
`ifdef PATTERN_FEEDER_REPEAT_EN
                  nxt     = S_LOAD;
                  nxt_rep = 1'b1;
                  nxt_val = last_val;
`else
                  nxt     = S_IDLE;
`endif
               end
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         hcnt     <= '0;
         rep_q    <= 1'b0;
         load_val <= 8'h00;
         load_en  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= nxt;
         rep_q    <= nxt_rep;
         load_val <= nxt_val;
         load_en  <= (nxt == S_LOAD);
         busy     <= (nxt != S_IDLE);
         if (state == S_LOAD)
            hcnt <= hold_cnt;
         else if (state == S_HOLD)
            hcnt <= hcnt - HOLD_W'(1);
      end
   end

`ifdef PATTERN_FEEDER_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst)
         last_val <= 8'h00;
      else if (state == S_LOAD)
         last_val <= load_val;
   end
`endif

endmodule

// File: tb/tb_pattern_feeder.sv
// tb_pattern_feeder: vector table plus scoreboard of loaded bytes and load spacing.
// Repeat-mode sequence is selected with PATTERN_FEEDER_REPEAT_EN.
module tb_pattern_feeder;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] hold_cnt;
   logic [7:0] load_val;
   logic       load_en;
   logic       busy;
   logic [2:0] level;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [7:0] q[$];
   logic [7:0] last_b;
   bit         have_last = 0;
   int         exp_gap = 0;
   int         prev_cyc = 0;
   bit         have_prev = 0;
   int         seg_loads = 0;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] d;
      logic [3:0] h;
      logic       en;
      logic [7:0] val;
      logic       bsy;
      logic [2:0] lvl;
      logic       rdy;
   } vec_t;

   vec_t tbl [9];

   pattern_feeder #(.DEPTH(4), .HOLD_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .hold_cnt (hold_cnt),
      .load_val (load_val),
      .load_en  (load_en),
      .busy     (busy),
      .level    (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: got timeout, required event within bound", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic seg_start(input int gap);
      exp_gap   = gap;
      have_prev = 0;
      seg_loads = 0;
   endtask

   task automatic push1(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      q.push_back(d);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim, input string nm);
      int t = 0;
      while (busy && t < lim) begin
         tick();
         t++;
      end
      if (busy)
         fail(nm);
   endtask

   task automatic wait_loads(input int n, input int lim, input string nm);
      int t = 0;
      while (seg_loads < n && t < lim) begin
         tick();
         t++;
      end
      if (seg_loads < n)
         fail(nm);
   endtask

   // Scoreboard: every strobe must match the next queued byte (or the
   // last byte when repeating) and respect the expected spacing.
   always @(negedge clk) begin
      if (load_en === 1'b1) begin
         seg_loads++;
         if (have_prev && exp_gap != 0)
            chk("load_gap", cyc - prev_cyc, exp_gap);
         have_prev = 1;
         prev_cyc  = cyc;
         if (q.size() != 0) begin
            last_b    = q.pop_front();
            have_last = 1;
            chk("load_val", load_val, last_b);
         end else begin
`ifdef PATTERN_FEEDER_REPEAT_EN
            if (have_last)
               chk("repeat_val", load_val, last_b);
            else
               fail("unexpected_load");
`else
            n_vec++;
            n_err++;
            $display("FAIL unexpected_load: got load_val %0h, required no load", load_val);
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      hold_cnt = 4'd3;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 4'd3, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 4'd3, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 8'hA5, 4'd3, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 4'd3, 1'b1, 8'hA5, 1'b1, 3'd1, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 4'd3, 1'b0, 8'hA5, 1'b1, 3'd0, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 4'd9, 1'b0, 8'hA5, 1'b1, 3'd0, 1'b1};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 4'd9, 1'b0, 8'hA5, 1'b1, 3'd0, 1'b1};
`ifdef PATTERN_FEEDER_REPEAT_EN
      tbl[7] = '{1'b0, 1'b0, 8'h00, 4'd9, 1'b1, 8'hA5, 1'b1, 3'd0, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 8'h00, 4'd9, 1'b0, 8'hA5, 1'b1, 3'd0, 1'b1};
`else
      tbl[7] = '{1'b0, 1'b0, 8'h00, 4'd9, 1'b0, 8'hA5, 1'b0, 3'd0, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 8'h00, 4'd9, 1'b0, 8'hA5, 1'b0, 3'd0, 1'b1};
`endif

      seg_start(0);
      for (int i = 0; i < 9; i++) begin
         rst      = tbl[i].rst;
         in_valid = tbl[i].vld;
         in_data  = tbl[i].d;
         hold_cnt = tbl[i].h;
         if (tbl[i].vld && !tbl[i].rst)
            q.push_back(tbl[i].d);
         tick();
         chk($sformatf("v%0d_load_en", i), load_en, tbl[i].en);
         chk($sformatf("v%0d_load_val", i), load_val, tbl[i].val);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("v%0d_level", i), level, tbl[i].lvl);
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].rdy);
      end
      in_valid = 1'b0;

`ifdef PATTERN_FEEDER_REPEAT_EN
      rst = 1'b1;
      tick();
      tick();
      q.delete();
      have_last = 0;
      rst = 1'b0;
      chk("rpt_rst_busy", busy, 1'b0);

      hold_cnt = 4'd2;
      seg_start(3);
      push1(8'h81);
      wait_loads(4, 40, "rpt_81_loads");
      begin
         int t = 0;
         while (load_en !== 1'b1 && t < 10) begin
            tick();
            t++;
         end
         if (load_en !== 1'b1)
            fail("rpt_find_load");
      end
      @(negedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      q.push_back(8'h3C);
      tick();
      in_valid = 1'b0;
      begin
         int n = seg_loads;
         wait_loads(n + 3, 40, "rpt_3c_loads");
      end
      chk("rpt_busy", busy, 1'b1);
      chk("rpt_level", level, 3'd0);
      chk("rpt_q_drained", q.size(), 0);
`else
      // Back-to-back loads with zero hold.
      hold_cnt = 4'd0;
      seg_start(1);
      for (int d = 1; d <= 4; d++) begin
         chk("b2b_rdy", in_ready, 1'b1);
         push1(d[7:0]);
      end
      wait_idle(30, "b2b_idle");
      chk("b2b_loads", seg_loads, 4);
      chk("b2b_level", level, 3'd0);

      // Full FIFO back-pressure with 8-cycle load spacing.
      hold_cnt = 4'd7;
      seg_start(8);
      for (int i = 0; i < 6; i++) begin
         bit acc;
         int t;
         in_valid = 1'b1;
         in_data  = 8'h10 + i[7:0];
         q.push_back(in_data);
         t = 0;
         do begin
            acc = in_ready;
            chk("full_rdy", in_ready, level != 3'd4);
            tick();
            t++;
         end while (!acc && t < 60);
         if (!acc)
            fail("full_accept");
      end
      in_valid = 1'b0;
      wait_idle(120, "full_idle");
      chk("full_loads", seg_loads, 6);
      chk("full_level", level, 3'd0);

      // Reset in the second hold cycle with bytes still queued.
      hold_cnt = 4'd5;
      seg_start(0);
      push1(8'hB1);
      in_valid = 1'b1;
      in_data  = 8'hB2;
      q.push_back(8'hB2);
      tick();
      chk("lat_en", load_en, 1'b1);
      chk("lat_val", load_val, 8'hB1);
      push1(8'hB3);
      chk("hold1_en", load_en, 1'b0);
      chk("hold1_busy", busy, 1'b1);
      tick();
      chk("hold2_level", level, 3'd2);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      q.delete();
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("mrst_level", level, 3'd0);
      chk("mrst_en", load_en, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_val", load_val, 8'h00);
      chk("mrst_rdy", in_ready, 1'b1);
      seg_start(0);
      for (int i = 0; i < 16; i++)
         tick();
      chk("post_rst_loads", seg_loads, 0);
      chk("post_rst_level", level, 3'd0);
      chk("post_rst_busy", busy, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
